// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory responder.
package imem_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned DEPTH_WORDS_DEF = 256;
    localparam int unsigned LATENCY_DEF     = 2;
    localparam int unsigned OUTSTANDING_DEF = 4;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } imem_rsp_t;

    // Word-aligned and inside the populated word range.
    function automatic logic word_addr_ok(input logic [XLEN-1:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (32'(addr[XLEN-1:2]) < depth);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Return-queue FIFO holding fetch responses until the consumer takes them.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = OUTSTANDING_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  imem_rsp_t push_data,
    input  logic      pop,
    input  logic      flush,
    output imem_rsp_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    imem_rsp_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with fixed-latency read pipeline, credit-limited
// request acceptance and an in-order return queue.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned LATENCY     = LATENCY_DEF,
    parameter int unsigned OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            rsp_ready,
    input  logic            flush,
    input  logic            ld_en,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    logic [XLEN-1:0]    mem [DEPTH_WORDS];
    logic [CNT_W-1:0]   out_cnt;
    logic               run;
    logic               accept;
    logic               pop;
    logic               rd_ok;
    logic               ld_ok;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   ld_idx;
    imem_rsp_t          rd_rsp;
    logic [LATENCY-1:0] pipe_vld;
    imem_rsp_t          pipe_rsp [LATENCY];
    imem_rsp_t          head;
    logic               fifo_full;
    logic               fifo_empty;

    assign req_ready = run && (out_cnt < CNT_W'(OUTSTANDING)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready && !flush;

    assign rd_ok  = word_addr_ok(req_addr, DEPTH_WORDS);
    assign ld_ok  = word_addr_ok(ld_addr, DEPTH_WORDS);
    assign rd_idx = rd_ok ? req_addr[IDX_W+1:2] : '0;
    assign ld_idx = ld_ok ? ld_addr[IDX_W+1:2] : '0;

    // Bad addresses never touch the array and return a zero word with err set.
    always_comb begin
        rd_rsp      = '0;
        rd_rsp.err  = !rd_ok;
        if (rd_ok) begin
            rd_rsp.data = mem[rd_idx];
        end
    end

    // Contents survive reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_rsp[i] <= '0;
            end
        end else if (flush) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            if (accept) begin
                pipe_rsp[0] <= rd_rsp;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_rsp[i] <= pipe_rsp[i-1];
            end
        end
    end

    // Credits cover pipeline plus queue, so the queue always has room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (flush) begin
                out_cnt <= '0;
            end else begin
                case ({accept, pop})
                    2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                    2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                    default: out_cnt <= out_cnt;
                endcase
            end
        end
    end

    imem_rsp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld[LATENCY-1] && !fifo_full),
        .push_data (pipe_rsp[LATENCY-1]),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = head.data;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder with directed fetch/flush/reset vectors.
module tb_imem_responder;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready = 1'b1;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    int checks = 0;
    int errors = 0;
    imem_rsp_t exp_q[$];

    logic [31:0] b_addr [6];
    logic [31:0] b_data [6];
    int k;

    imem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .OUTSTANDING (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: every presented response must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && !flush && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_rsp got data=%h err=%b want no response t=%0t", rsp_data, rsp_err, $time);
            end else begin
                check("rsp_data", rsp_data, exp_q[0].data);
                check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick(1);
        ld_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic e);
        imem_rsp_t x;
        bit done;
        done = 0;
        x.data = d; x.err = e;
        req_valid = 1'b1; req_addr = a;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(x);
                done = 1;
            end
            tick(1);
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no accept want accept addr=%h", a);
        end
    endtask

    task automatic burst(input int ncyc, input int last);
        imem_rsp_t x;
        for (int c = 0; c < ncyc && k < last; c++) begin
            req_valid = 1'b1; req_addr = b_addr[k];
            @(negedge clk);
            if (req_ready) begin
                x.data = b_data[k]; x.err = 1'b0;
                exp_q.push_back(x);
                k++;
            end
            tick(1);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || rsp_valid); i++) tick(1);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        tick(1);
        flush = 1'b0;
    endtask

    initial begin
        b_addr[0] = 32'h0;  b_data[0] = 32'h0000_0013;
        b_addr[1] = 32'h4;  b_data[1] = 32'h0050_0093;
        b_addr[2] = 32'h8;  b_data[2] = 32'h00A0_0113;
        b_addr[3] = 32'hC;  b_data[3] = 32'h2222_2222;
        b_addr[4] = 32'h10; b_data[4] = 32'h1111_1111;
        b_addr[5] = 32'h0;  b_data[5] = 32'h0000_0013;

        // Reset values
        tick(3);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Program load, including writes that must be dropped
        load(32'h0,   32'h0000_0013);
        load(32'h4,   32'h0050_0093);
        load(32'h8,   32'h00A0_0113);
        load(32'hC,   32'h2222_2222);
        load(32'h10,  32'h1111_1111);
        load(32'h3FC, 32'hCAFE_F00D);
        load(32'h12,  32'hBAD0_BAD0);
        load(32'h400, 32'hBAD0_0000);

        // Back-to-back fetch latency
        rsp_ready = 1'b1;
        send(32'h0, 32'h0000_0013, 1'b0);
        send(32'h4, 32'h0050_0093, 1'b0);
        @(negedge clk);
        check("lat_early_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat2_valid", 32'(rsp_valid), 32'd1);
        check("lat2_data", rsp_data, 32'h0000_0013);
        @(negedge clk);
        check("lat3_valid", 32'(rsp_valid), 32'd1);
        check("lat3_data", rsp_data, 32'h0050_0093);
        tick(1);
        wait_drain();

        // Misaligned, out of range, last word
        send(32'h2,   32'h0, 1'b1);
        send(32'h400, 32'h0, 1'b1);
        send(32'h3FC, 32'hCAFE_F00D, 1'b0);
        wait_drain();

        // Credit limit under backpressure
        rsp_ready = 1'b0;
        k = 0;
        burst(8, 6);
        check("stall_accepted", 32'(k), 32'd4);
        check("stall_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        burst(40, 6);
        check("resume_accepted", 32'(k), 32'd6);
        wait_drain();

        // Flush with requests in flight
        send(32'h0, 32'h0000_0013, 1'b0);
        send(32'h4, 32'h0050_0093, 1'b0);
        send(32'hC, 32'h2222_2222, 1'b0);
        do_flush();
        @(negedge clk);
        check("flush_valid", 32'(rsp_valid), 32'd0);
        tick(5);
        send(32'h8, 32'h00A0_0113, 1'b0);
        wait_drain();

        // Flush returns all credits
        rsp_ready = 1'b0;
        k = 0;
        burst(8, 6);
        do_flush();
        k = 0;
        burst(8, 6);
        check("post_flush_credit", 32'(k), 32'd4);
        do_flush();
        rsp_ready = 1'b1;

        // Read-before-write on the same word
        ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
        send(32'h10, 32'h1111_1111, 1'b0);
        ld_en = 1'b0;
        send(32'h10, 32'hDEAD_BEEF, 1'b0);
        wait_drain();

        // Asynchronous reset with responses pending
        rsp_ready = 1'b0;
        send(32'h0, 32'h0000_0013, 1'b0);
        send(32'h4, 32'h0050_0093, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick(1);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rerun_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        send(32'h0,  32'h0000_0013, 1'b0);
        send(32'h10, 32'hDEAD_BEEF, 1'b0);
        send(32'h4,  32'h0050_0093, 1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored.
REQ-002 SHALL have parameter LATENCY, default 2, range 1..4, cycles from request acceptance to earliest response.
REQ-003 SHALL have parameter OUTSTANDING, default 4, range 2..8, maximum accepted-but-unconsumed requests.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_addr  input  32  byte address of instruction (PC value).
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 rsp_valid  output  1  response at head of return queue.
REQ-010 rsp_data  output  32  instruction word.
REQ-011 rsp_err  output  1  request was misaligned or out of range.
REQ-012 rsp_ready  input  1  consumer accepts response this cycle.
REQ-013 flush  input  1  discard all in-flight and queued responses (branch/jump redirect).
REQ-014 ld_en  input  1  memory load write enable (program loading).
REQ-015 ld_addr  input  32  byte address for load write.
REQ-016 ld_data  input  32  word written on load.

Function
REQ-017 Request SHALL be accepted when req_valid && req_ready at a rising edge.
REQ-018 req_ready SHALL equal (outstanding count < OUTSTANDING) && !flush.
REQ-019 Outstanding count SHALL increment on accept, decrement on response handshake (rsp_valid && rsp_ready), be unchanged when both occur, and go to 0 on flush.
REQ-020 Memory SHALL be read at the acceptance edge using word index req_addr[31:2]; stored value SHALL then travel a LATENCY-stage valid-tagged pipeline.
REQ-021 rsp_err SHALL be 1 and rsp_data 0 when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS; memory SHALL not be indexed out of range.
REQ-022 Pipeline output SHALL be pushed into an OUTSTANDING-deep FIFO; rsp_valid/rsp_data/rsp_err SHALL be driven from the FIFO head.
REQ-023 With empty FIFO and rsp_ready held 1, response SHALL appear exactly LATENCY cycles after acceptance; back-to-back accepts SHALL yield back-to-back responses (one per cycle).
REQ-024 Responses SHALL be returned in acceptance order; none SHALL be dropped or duplicated except by flush.
REQ-025 rsp_data/rsp_err SHALL stay stable while rsp_valid && !rsp_ready.
REQ-026 FIFO SHALL never overflow; credit scheme of REQ-018 guarantees space for every pipeline entry.
REQ-027 flush SHALL clear all pipeline valid bits and the FIFO at that edge; rsp_valid SHALL be 0 the following cycle; a response handshake in the flush cycle SHALL be ignored for counting.
REQ-028 ld_en SHALL write ld_data to word ld_addr[31:2] when in range and ld_addr[1:0]==0; otherwise the write SHALL be ignored.
REQ-029 Read and load to the same word in the same cycle SHALL return old data (read-before-write).

Reset
REQ-030 On rst asserted: outstanding count 0, pipeline valids 0, FIFO empty, rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 0 while rst is high, 1 first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight responses; memory contents SHALL NOT be reset.

Structure
REQ-032 Shared package imem_pkg SHALL hold XLEN=32, default DEPTH_WORDS/LATENCY/OUTSTANDING constants, and struct imem_rsp_t {data[31:0], err}.
REQ-033 FIFO SHALL be sub-module imem_rsp_fifo (parameterised depth, imem_rsp_t payload, push/pop/flush, full/empty flags).

Verification
REQ-034 Load words 0x00000013 at 0x0 and 0x00500093 at 0x4; requests 0x0, 0x4 back-to-back, rsp_ready=1, LATENCY=2 -> rsp 0x00000013 at cycle 2, 0x00500093 at cycle 3, rsp_err=0.
REQ-035 Request 0x2 -> rsp_err=1, rsp_data=0; request 0x400 with DEPTH_WORDS=256 -> rsp_err=1.
REQ-036 rsp_ready=0, issue 6 requests with OUTSTANDING=4 -> exactly 4 accepted, req_ready=0 after fourth; release rsp_ready -> 4 responses in order, then remaining 2 accepted.
REQ-037 3 requests in flight, assert flush one cycle -> rsp_valid=0 next cycle, count 0, no stale response ever appears; new request 0x8 returns word at 0x8 after LATENCY.
REQ-038 Same-cycle load 0xDEADBEEF and request at 0x10 (old 0x11111111) -> response 0x11111111; repeat request -> 0xDEADBEEF.
REQ-039 Assert rst asynchronously with 2 responses pending -> rsp_valid drops immediately, req_ready 1 one cycle after release, memory intact.
